// File: rtl/msp430_prog_loader.sv
// Purpose: host-side program loader; parses sync/count/address/data/checksum frames and writes 16-bit words to imem.
// Latency: the write strobe fires the cycle after the high data byte is accepted; status follows the checksum byte by one cycle.
// Backpressure: Byte_ready stays high in every receive state (one byte per cycle) and drops only in DONE/ERR until Clr.
module msp430_prog_loader #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned MAX_WORDS   = 1024,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [7:0]        Byte_in,
    input  logic              Byte_valid,
    output logic              Byte_ready,
    input  logic              Clr,
    output logic [ADDR_W-1:0] Mem_addr,
    output logic [15:0]       Mem_data,
    output logic              Mem_wr_en,
    output logic              Load_en,
    output logic              Done,
    output logic              Error
);

    localparam logic [7:0]       SYNC_BYTE = 8'hA5;
    localparam int unsigned      TMO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CNT_LO,
        ST_CNT_HI,
        ST_ADR_LO,
        ST_ADR_HI,
        ST_DAT_LO,
        ST_DAT_HI,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t            state_q,     state_d;
    logic [7:0]        cnt_lo_q,    cnt_lo_d;
    logic [15:0]       remaining_q, remaining_d;
    logic [7:0]        adr_lo_q,    adr_lo_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [7:0]        dat_lo_q,    dat_lo_d;
    logic [15:0]       mem_data_q,  mem_data_d;
    logic              wr_en_q,     wr_en_d;
    logic [7:0]        chk_q,       chk_d;
    logic [TMO_W-1:0]  tmo_q,       tmo_d;

    logic accept;
    logic in_frame;

    assign in_frame   = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERR);
    assign Byte_ready = (state_q != ST_DONE) && (state_q != ST_ERR);
    assign accept     = Byte_valid && Byte_ready;

    assign Mem_addr  = addr_q;
    assign Mem_data  = mem_data_q;
    assign Mem_wr_en = wr_en_q;
    assign Load_en   = (state_q != ST_DONE);
    assign Done      = (state_q == ST_DONE);
    assign Error     = (state_q == ST_ERR);

    // Frame parser: next state, field capture, running XOR, idle timeout and write strobe.
    always_comb begin
        state_d     = state_q;
        cnt_lo_d    = cnt_lo_q;
        remaining_d = remaining_q;
        adr_lo_d    = adr_lo_q;
        addr_d      = addr_q;
        dat_lo_d    = dat_lo_q;
        mem_data_d  = mem_data_q;
        wr_en_d     = 1'b0;
        chk_d       = chk_q;
        tmo_d       = tmo_q;

        // Address advances once the write it belongs to has been presented.
        if (wr_en_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        if (Clr) begin
            // Abort or release: back to IDLE; words already written stay in memory.
            state_d = ST_IDLE;
            chk_d   = '0;
            tmo_d   = '0;
        end else if (accept) begin
            // An accepted byte always beats a timeout expiring in the same cycle.
            tmo_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (Byte_in == SYNC_BYTE) begin
                        state_d = ST_CNT_LO;
                    end
                end
                ST_CNT_LO: begin
                    cnt_lo_d = Byte_in;
                    chk_d    = chk_q ^ Byte_in;
                    state_d  = ST_CNT_HI;
                end
                ST_CNT_HI: begin
                    remaining_d = {Byte_in, cnt_lo_q};
                    chk_d       = chk_q ^ Byte_in;
                    state_d     = (32'({Byte_in, cnt_lo_q}) > MAX_WORDS) ? ST_ERR : ST_ADR_LO;
                end
                ST_ADR_LO: begin
                    adr_lo_d = Byte_in;
                    chk_d    = chk_q ^ Byte_in;
                    state_d  = ST_ADR_HI;
                end
                ST_ADR_HI: begin
                    addr_d  = ADDR_W'({Byte_in, adr_lo_q});
                    chk_d   = chk_q ^ Byte_in;
                    state_d = (remaining_q == 16'd0) ? ST_CHK : ST_DAT_LO;
                end
                ST_DAT_LO: begin
                    dat_lo_d = Byte_in;
                    chk_d    = chk_q ^ Byte_in;
                    state_d  = ST_DAT_HI;
                end
                ST_DAT_HI: begin
                    mem_data_d  = {Byte_in, dat_lo_q};
                    wr_en_d     = 1'b1;
                    chk_d       = chk_q ^ Byte_in;
                    remaining_d = remaining_q - 16'd1;
                    state_d     = (remaining_q == 16'd1) ? ST_CHK : ST_DAT_LO;
                end
                ST_CHK: begin
                    state_d = (Byte_in == chk_q) ? ST_DONE : ST_ERR;
                end
                default: begin
                end
            endcase
        end else if (in_frame) begin
            // Mid-frame silence: give up once the idle budget is used.
            if (tmo_q == TMO_LAST) begin
                state_d = ST_ERR;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    // State and datapath registers; reset also kills any pending write strobe.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= ST_IDLE;
            cnt_lo_q    <= '0;
            remaining_q <= '0;
            adr_lo_q    <= '0;
            addr_q      <= '0;
            dat_lo_q    <= '0;
            mem_data_q  <= '0;
            wr_en_q     <= 1'b0;
            chk_q       <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_lo_q    <= cnt_lo_d;
            remaining_q <= remaining_d;
            adr_lo_q    <= adr_lo_d;
            addr_q      <= addr_d;
            dat_lo_q    <= dat_lo_d;
            mem_data_q  <= mem_data_d;
            wr_en_q     <= wr_en_d;
            chk_q       <= chk_d;
            tmo_q       <= tmo_d;
        end
    end

endmodule

// File: tb/tb_msp430_prog_loader.sv
// Bench for msp430_prog_loader: two instances (16-bit address / long timeout, 4-bit address / 8-cycle timeout)
// share one byte stream; a frame-position model predicts status and writes, checked every cycle.
// Directed frames pin the model with literal expectations, then randomized frames follow.
`timescale 1ns/1ps
module tb_msp430_prog_loader;

    localparam int MAXW  = 1024;
    localparam int AW_A  = 16;
    localparam int AW_B  = 4;
    localparam int TMO_A = 65535;
    localparam int TMO_B = 8;

    localparam int P_IDLE = 0;
    localparam int P_RECV = 1;
    localparam int P_DONE = 2;
    localparam int P_ERR  = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       clr;

    logic        a_rdy, a_wr, a_load, a_done, a_err;
    logic [15:0] a_addr, a_data;
    logic        b_rdy, b_wr, b_load, b_done, b_err;
    logic [3:0]  b_addr;
    logic [15:0] b_data;

    always #5 clk = ~clk;

    msp430_prog_loader #(.ADDR_W(AW_A), .MAX_WORDS(MAXW), .TIMEOUT_CYC(TMO_A)) dut_a (
        .Clk(clk), .Rst(rst_n), .Byte_in(byte_in), .Byte_valid(byte_valid), .Byte_ready(a_rdy),
        .Clr(clr), .Mem_addr(a_addr), .Mem_data(a_data), .Mem_wr_en(a_wr),
        .Load_en(a_load), .Done(a_done), .Error(a_err)
    );

    msp430_prog_loader #(.ADDR_W(AW_B), .MAX_WORDS(MAXW), .TIMEOUT_CYC(TMO_B)) dut_b (
        .Clk(clk), .Rst(rst_n), .Byte_in(byte_in), .Byte_valid(byte_valid), .Byte_ready(b_rdy),
        .Clr(clr), .Mem_addr(b_addr), .Mem_data(b_data), .Mem_wr_en(b_wr),
        .Load_en(b_load), .Done(b_done), .Error(b_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model: tracks byte position within the frame ----------------
    int          aw_of[2]  = '{AW_A, AW_B};
    int          tmo_of[2] = '{TMO_A, TMO_B};
    int          m_phase[2];
    int          m_idx[2];
    int          m_idle[2];
    logic [15:0] m_cnt[2];
    logic [15:0] m_base[2];
    logic [7:0]  m_chk[2];
    logic [7:0]  m_lo[2];
    logic        e_wr[2];
    logic [15:0] e_addr[2];
    logic [15:0] e_data[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = P_IDLE; m_idx[i] = 0; m_idle[i] = 0;
            m_cnt[i] = '0; m_base[i] = '0; m_chk[i] = '0; m_lo[i] = '0;
            e_wr[i] = 1'b0; e_addr[i] = '0; e_data[i] = '0;
        end
    endtask

    // One clock edge worth of frame progress for both instances.
    task automatic model_step(input logic [7:0] b, input logic v, input logic c);
        int k;
        int a;
        for (int i = 0; i < 2; i++) begin
            e_wr[i] = 1'b0;
            if (c) begin
                m_phase[i] = P_IDLE; m_idx[i] = 0; m_chk[i] = '0; m_idle[i] = 0;
            end else if (m_phase[i] == P_IDLE) begin
                if (v && b == 8'hA5) begin
                    m_phase[i] = P_RECV; m_idx[i] = 0; m_chk[i] = '0; m_idle[i] = 0;
                end
            end else if (m_phase[i] == P_RECV) begin
                if (v) begin
                    m_idle[i] = 0;
                    k = m_idx[i] - 4;
                    if (m_idx[i] < 4) begin
                        m_chk[i] ^= b;
                        case (m_idx[i])
                            0: m_cnt[i][7:0] = b;
                            1: begin
                                m_cnt[i][15:8] = b;
                                if (int'(m_cnt[i]) > MAXW) m_phase[i] = P_ERR;
                            end
                            2: m_base[i][7:0] = b;
                            default: m_base[i][15:8] = b;
                        endcase
                    end else if (k < 2 * int'(m_cnt[i])) begin
                        m_chk[i] ^= b;
                        if (k % 2 == 0) begin
                            m_lo[i] = b;
                        end else begin
                            a = (int'(m_base[i]) + k / 2) % (1 << aw_of[i]);
                            e_wr[i]   = 1'b1;
                            e_addr[i] = 16'(a);
                            e_data[i] = {b, m_lo[i]};
                        end
                    end else begin
                        m_phase[i] = (b == m_chk[i]) ? P_DONE : P_ERR;
                    end
                    m_idx[i]++;
                end else begin
                    m_idle[i]++;
                    if (m_idle[i] == tmo_of[i]) begin
                        m_phase[i] = P_ERR;
                        m_idle[i]  = 0;
                    end
                end
            end
        end
    endtask

    // ---------------- compare process ----------------
    logic        cmp_en = 1'b0;
    logic [31:0] wlog_a[$];
    logic [31:0] wlog_b[$];

    task automatic cmp(input int i, input logic rdy, input logic load, input logic done,
                       input logic err, input logic wr, input logic [15:0] addr, input logic [15:0] data);
        string s;
        s = (i == 0) ? "a" : "b";
        check({s, ".ready"},  32'(rdy),  32'(m_phase[i] == P_IDLE || m_phase[i] == P_RECV));
        check({s, ".load_en"}, 32'(load), 32'(m_phase[i] != P_DONE));
        check({s, ".done"},   32'(done), 32'(m_phase[i] == P_DONE));
        check({s, ".error"},  32'(err),  32'(m_phase[i] == P_ERR));
        check({s, ".wr_en"},  32'(wr),   32'(e_wr[i]));
        if (e_wr[i]) begin
            check({s, ".wr_addr"}, 32'(addr), 32'(e_addr[i]));
            check({s, ".wr_data"}, 32'(data), 32'(e_data[i]));
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp(0, a_rdy, a_load, a_done, a_err, a_wr, a_addr, a_data);
            cmp(1, b_rdy, b_load, b_done, b_err, b_wr, {12'd0, b_addr}, b_data);
            if (a_wr) wlog_a.push_back({a_addr, a_data});
            if (b_wr) wlog_b.push_back({12'd0, b_addr, b_data});
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] fq[$];

    task automatic cyc(input logic [7:0] b, input logic v, input logic c);
        byte_in = b; byte_valid = v; clr = c;
        @(posedge clk);
        model_step(b, v, c);
        @(negedge clk);
        #1;
    endtask

    task automatic idle_cyc(input int n);
        for (int j = 0; j < n; j++) cyc(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    endtask

    task automatic send_fq(input int gapmode);
        int g;
        foreach (fq[j]) begin
            if (gapmode != 0) begin
                g = ($urandom_range(0, 29) == 0) ? $urandom_range(9, 10) : $urandom_range(0, 1);
                idle_cyc(g);
            end
            cyc(fq[j], 1'b1, 1'b0);
        end
    endtask

    task automatic pulse_clr();
        cyc(8'h00, 1'b0, 1'b1);
        idle_cyc(1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".a_wr"},   32'(a_wr),   32'd0);
        check({tag, ".a_addr"}, 32'(a_addr), 32'd0);
        check({tag, ".a_data"}, 32'(a_data), 32'd0);
        check({tag, ".a_rdy"},  32'(a_rdy),  32'd1);
        check({tag, ".a_load"}, 32'(a_load), 32'd1);
        check({tag, ".a_done"}, 32'(a_done), 32'd0);
        check({tag, ".a_err"},  32'(a_err),  32'd0);
        check({tag, ".b_wr"},   32'(b_wr),   32'd0);
        check({tag, ".b_addr"}, 32'(b_addr), 32'd0);
        check({tag, ".b_load"}, 32'(b_load), 32'd1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int first_err;
        int nlog;
        int n;
        logic [15:0] cnt;
        logic [15:0] adr;
        logic [7:0]  cx;
        logic [7:0]  d;

        rst_n = 1'b0; byte_in = 8'h00; byte_valid = 1'b0; clr = 1'b0;
        model_reset();
        #1;
        check_reset_vals("reset");
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // Two-word frame, back to back; checksum of count/address/data bytes is 0x1A.
        wlog_a.delete(); wlog_b.delete();
        fq = {8'hA5, 8'h02, 8'h00, 8'h10, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h1A};
        send_fq(0);
        check("t1.model_chk", 32'(m_chk[0]), 32'h1A);
        check("t1.a_writes", wlog_a.size(), 2);
        if (wlog_a.size() == 2) begin
            check("t1.a_w0", wlog_a[0], 32'h0010_1234);
            check("t1.a_w1", wlog_a[1], 32'h0011_5678);
        end
        if (wlog_b.size() == 2) begin
            check("t1.b_w0", wlog_b[0], 32'h0000_1234);
            check("t1.b_w1", wlog_b[1], 32'h0001_5678);
        end
        check("t1.a_done", 32'(a_done), 32'd1);
        check("t1.a_load", 32'(a_load), 32'd0);
        pulse_clr();
        check("t1.clr_load", 32'(a_load), 32'd1);

        // Same frame with a bad checksum byte.
        wlog_a.delete(); wlog_b.delete();
        fq = {8'hA5, 8'h02, 8'h00, 8'h10, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h00};
        send_fq(0);
        check("t2.a_writes", wlog_a.size(), 2);
        check("t2.a_err",  32'(a_err),  32'd1);
        check("t2.a_load", 32'(a_load), 32'd1);
        check("t2.a_rdy",  32'(a_rdy),  32'd0);
        pulse_clr();
        check("t2.clr_err", 32'(a_err), 32'd0);
        check("t2.clr_rdy", 32'(a_rdy), 32'd1);

        // Junk before sync, then an empty frame.
        wlog_a.delete(); wlog_b.delete();
        fq = {8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_fq(0);
        check("t3.writes", wlog_a.size() + wlog_b.size(), 0);
        check("t3.a_done", 32'(a_done), 32'd1);
        check("t3.b_done", 32'(b_done), 32'd1);
        pulse_clr();

        // Address 0x000F, two words: wraps on the 4-bit instance.
        wlog_a.delete(); wlog_b.delete();
        fq = {8'hA5, 8'h02, 8'h00, 8'h0F, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h49};
        send_fq(0);
        if (wlog_b.size() == 2) begin
            check("t4.b_w0", wlog_b[0], 32'h000F_2211);
            check("t4.b_w1", wlog_b[1], 32'h0000_4433);
        end else begin
            check("t4.b_writes", wlog_b.size(), 2);
        end
        if (wlog_a.size() == 2) check("t4.a_w1", wlog_a[1], 32'h0010_4433);
        check("t4.b_done", 32'(b_done), 32'd1);
        pulse_clr();

        // Count 0x0401 exceeds the limit: error right after the count.
        wlog_a.delete(); wlog_b.delete();
        fq = {8'hA5, 8'h01, 8'h04};
        send_fq(0);
        check("t5.a_err", 32'(a_err), 32'd1);
        check("t5.b_err", 32'(b_err), 32'd1);
        idle_cyc(2);
        check("t5.writes", wlog_a.size() + wlog_b.size(), 0);
        pulse_clr();

        // Count exactly at the limit is accepted.
        wlog_a.delete(); wlog_b.delete();
        fq = {8'hA5, 8'h00, 8'h04, 8'h00, 8'h80};
        cx = 8'h00 ^ 8'h04 ^ 8'h00 ^ 8'h80;
        for (int j = 0; j < 2048; j++) begin
            d = 8'($urandom_range(0, 255));
            fq.push_back(d);
            cx ^= d;
        end
        fq.push_back(cx);
        send_fq(0);
        check("t5b.a_done", 32'(a_done), 32'd1);
        check("t5b.a_writes", wlog_a.size(), 1024);
        pulse_clr();

        // Stall mid-data: the 8-cycle instance errors on the 8th idle cycle.
        wlog_a.delete(); wlog_b.delete();
        fq = {8'hA5, 8'h01, 8'h00, 8'h20, 8'h00, 8'h77};
        send_fq(0);
        first_err = -1;
        for (int j = 0; j < 10; j++) begin
            cyc(8'h00, 1'b0, 1'b0);
            if (b_err && first_err < 0) first_err = j + 1;
        end
        check("t6.tmo_cycle", first_err, 8);
        check("t6.a_err", 32'(a_err), 32'd0);
        fq = {8'h66, 8'h30};
        send_fq(0);
        check("t6.a_done", 32'(a_done), 32'd1);
        if (wlog_a.size() == 1) check("t6.a_w0", wlog_a[0], 32'h0020_6677);
        pulse_clr();

        // Reset asserted while a write strobe is live.
        fq = {8'hA5, 8'h01, 8'h00, 8'h40, 8'h00, 8'hAB, 8'hCD};
        send_fq(0);
        check("t7.pre_wr", 32'(a_wr), 32'd1);
        nlog = wlog_a.size();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_vals("t7");
        @(negedge clk);
        #1 rst_n = 1'b1;
        idle_cyc(3);
        check("t7.no_write", wlog_a.size(), nlog);

        // Randomized frames: gaps, junk, bad checksums, oversize counts, aborts.
        for (int f = 0; f < 40; f++) begin
            fq = {};
            n = $urandom_range(0, 2);
            for (int j = 0; j < n; j++) begin
                d = 8'($urandom_range(0, 255));
                fq.push_back((d == 8'hA5) ? 8'h00 : d);
            end
            fq.push_back(8'hA5);
            cnt = ($urandom_range(0, 9) == 0) ? 16'(1025 + $urandom_range(0, 3000)) : 16'($urandom_range(0, 6));
            adr = 16'($urandom_range(0, 65535));
            fq.push_back(cnt[7:0]); fq.push_back(cnt[15:8]);
            cx = cnt[7:0] ^ cnt[15:8];
            if (int'(cnt) <= MAXW) begin
                fq.push_back(adr[7:0]); fq.push_back(adr[15:8]);
                cx ^= adr[7:0] ^ adr[15:8];
                for (int j = 0; j < 2 * int'(cnt); j++) begin
                    d = 8'($urandom_range(0, 255));
                    fq.push_back(d);
                    cx ^= d;
                end
                if ($urandom_range(0, 3) == 0) cx ^= 8'($urandom_range(1, 255));
                fq.push_back(cx);
            end
            if ($urandom_range(0, 7) == 0) begin
                n = $urandom_range(1, fq.size());
                fq = fq[0:n-1];
            end
            send_fq(1);
            idle_cyc($urandom_range(0, 2));
            pulse_clr();
        end

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
